// File: rtl/regfile_rr_arbiter.sv
// Four-entry DATA_W register bank behind one shared access port.
// NUM_REQ requesters are served round-robin, at most one access per cycle.
// A read returns its data one cycle after the grant, tagged with the requester id.

module regfile_rr_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  // Single storage register; loads only when its decoded write select fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (wr_en) q <= wdata;
  end

endmodule

module regfile_rr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [7:0]          reg_no,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          gnt,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic [1:0]          rid
);

  localparam int NUM_REQ  = 4;
  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;
  localparam int STAGES   = 1;

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  reg_no;
    logic [DATA_W-1:0] wdata;
  } acc_req_t;

  acc_req_t [NUM_REQ-1:0]           req_arr;
  acc_req_t                         sel;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [NUM_REGS-1:0]              wr_sel;
  logic [IDX_W-1:0]                 ptr;
  logic [IDX_W-1:0]                 gnt_idx;
  logic [IDX_W-1:0]                 cand;
  logic                             found;
  logic                             gnt_ok;
  logic                             rd_fire;
  logic [STAGES:1]                  vld_q;
  logic [STAGES:0]                  vld_pipe;

  // Slice the flat request buses into one struct per requester.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req_arr[i] = {we[i], reg_no[IDX_W*i +: IDX_W], wdata[DATA_W*i +: DATA_W]};
    end
  endgenerate

  // Round-robin search starting at ptr; the first asserted req wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant is suppressed while reset is held so nothing is consumed during reset.
  assign gnt_ok  = found & reset;
  assign gnt     = gnt_ok ? (4'b0001 << gnt_idx) : 4'b0000;
  assign sel     = req_arr[gnt_idx];
  assign rd_fire = gnt_ok & ~sel.we;

  // Read-valid pipeline: stage 0 is the grant cycle, stage STAGES drives rvalid.
  assign vld_pipe = {vld_q, rd_fire};
  assign rvalid   = vld_pipe[STAGES];

  // Write-select decode and per-register storage.
  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign wr_sel[r] = gnt_ok & sel.we & (sel.reg_no == IDX_W'(r));
      regfile_rr_entry #(.DATA_W(DATA_W)) u_entry (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_sel[r]),
        .wdata (sel.wdata),
        .q     (regs[r])
      );
    end
  endgenerate

  // Pointer advance past the winner, read capture, and valid pipeline shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      rdata <= '0;
      rid   <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (gnt_ok) ptr <= gnt_idx + IDX_W'(1);
      if (rd_fire) begin
        rdata <= regs[sel.reg_no];
        rid   <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Directed bench for regfile_rr_arbiter: a spec-level model checked every
// negedge, plus literal expectations at the scenario points.

module tb_regfile_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   we;
  logic [7:0]   reg_no;
  logic [127:0] wdata;
  logic [3:0]   gnt;
  logic [31:0]  rdata;
  logic         rvalid;
  logic [1:0]   rid;

  int errors = 0;
  int checks = 0;

  regfile_rr_arbiter #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .reg_no (reg_no),
    .wdata  (wdata),
    .gnt    (gnt),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rid    (rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr = 0;
  int unsigned m_regs [4] = '{0, 0, 0, 0};
  int unsigned m_rdata = 0;
  int          m_rid = 0;
  bit          m_rvalid = 0;

  function automatic int winner();
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (req[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr = 0;
      m_regs = '{0, 0, 0, 0};
      m_rdata = 0;
      m_rid = 0;
      m_rvalid = 0;
    end else begin
      int w;
      w = winner();
      m_rvalid = 0;
      if (w >= 0) begin
        int rn;
        rn = int'(reg_no[2*w +: 2]);
        if (we[w]) m_regs[rn] = wdata[32*w +: 32];
        else begin
          m_rdata = m_regs[rn];
          m_rid = w;
          m_rvalid = 1;
        end
        m_ptr = (w + 1) % 4;
      end
    end
  end

  // Compare DUT against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [3:0] eg;
    int w;
    w = winner();
    eg = (reset === 1'b1 && w >= 0) ? (4'b0001 << w) : 4'b0000;
    chk("model_gnt", {28'd0, gnt}, {28'd0, eg});
    chk("model_rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
    chk("model_rdata", rdata, m_rdata);
    chk("model_rid", {30'd0, rid}, m_rid);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input bit r, input bit w,
                          input logic [1:0] rn, input logic [31:0] wd);
    req[i] = r;
    we[i] = w;
    reg_no[2*i +: 2] = rn;
    wdata[32*i +: 32] = wd;
  endtask

  task automatic clear_all();
    req = '0;
    we = '0;
    reg_no = '0;
    wdata = '0;
  endtask

  task automatic all_read_own();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 2'(i), 32'd0);
  endtask

  logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  // Mixed traffic table: {req, we, reg_no}
  logic [15:0] mix_tbl [8] = '{
    {4'b1111, 4'b1111, 8'b00_01_10_11},
    {4'b1111, 4'b1111, 8'b00_01_10_11},
    {4'b0101, 4'b0000, 8'b11_10_01_00},
    {4'b1010, 4'b0010, 8'b00_11_01_10},
    {4'b1111, 4'b0000, 8'b00_01_10_11},
    {4'b1001, 4'b1000, 8'b10_00_00_01},
    {4'b0110, 4'b0000, 8'b00_10_10_00},
    {4'b1111, 4'b0101, 8'b11_11_11_11}
  };

  initial begin
    reset = 1'b0;
    clear_all();
    all_read_own();
    #3;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // Release reset away from any edge, then round-robin over all four reads.
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_gnt", {28'd0, gnt}, {28'd0, rr_seq[k]});
      tick();
      chk("rr_rid", {30'd0, rid}, k % 4);
      chk("rr_rvalid", {31'd0, rvalid}, 32'd1);
      chk("rr_rdata", rdata, 32'd0);
    end

    // Requester 2 writes reg 1, then reads it back.
    clear_all();
    set_lane(2, 1'b1, 1'b1, 2'd1, 32'hDEADBEEF);
    #1 chk("wr_gnt", {28'd0, gnt}, 32'b0100);
    tick();
    set_lane(2, 1'b1, 1'b0, 2'd1, 32'd0);
    #1 chk("wr_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rd_gnt", {28'd0, gnt}, 32'b0100);
    tick();
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_rid", {30'd0, rid}, 32'd2);
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);

    // Pointer skip (ptr=3, req=0110) and wrap (ptr=2, req=1001).
    clear_all();
    set_lane(1, 1'b1, 1'b0, 2'd1, 32'd0);
    set_lane(2, 1'b1, 1'b0, 2'd2, 32'd0);
    #1 chk("skip_gnt", {28'd0, gnt}, 32'b0010);
    tick();
    chk("skip_rid", {30'd0, rid}, 32'd1);
    chk("skip_rdata", rdata, 32'hDEADBEEF);
    clear_all();
    set_lane(0, 1'b1, 1'b0, 2'd0, 32'd0);
    set_lane(3, 1'b1, 1'b0, 2'd3, 32'd0);
    #1 chk("wrap_gnt", {28'd0, gnt}, 32'b1000);
    tick();
    chk("wrap_rid", {30'd0, rid}, 32'd3);

    // Write by 0 and read by 1 of reg 3 in the same cycle with ptr=0.
    clear_all();
    set_lane(0, 1'b1, 1'b1, 2'd3, 32'h12345678);
    set_lane(1, 1'b1, 1'b0, 2'd3, 32'd0);
    #1 chk("raw_wgnt", {28'd0, gnt}, 32'b0001);
    tick();
    set_lane(0, 1'b0, 1'b0, 2'd0, 32'd0);
    #1 chk("raw_rgnt", {28'd0, gnt}, 32'b0010);
    tick();
    chk("raw_rdata", rdata, 32'h12345678);
    chk("raw_rid", {30'd0, rid}, 32'd1);
    chk("raw_rvalid", {31'd0, rvalid}, 32'd1);

    // Idle: data holds, valid drops, pointer stays at 2.
    clear_all();
    for (int k = 0; k < 3; k++) begin
      #1 chk("idle_gnt", {28'd0, gnt}, 32'd0);
      tick();
      chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
      chk("idle_rdata", rdata, 32'h12345678);
    end
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 2'd3, 32'd0);
    #1 chk("idle_ptr_gnt", {28'd0, gnt}, 32'b0100);
    tick();
    chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    chk("pre_rst_rdata", rdata, 32'h12345678);

    // Mid-cycle reset with all requesting: outputs clear immediately.
    #2 reset = 1'b0;
    #1 chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_rid", {30'd0, rid}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    all_read_own();
    for (int k = 0; k < 4; k++) begin
      #1 chk("post_rst_gnt", {28'd0, gnt}, {28'd0, rr_seq[k]});
      tick();
      chk("post_rst_rdata", rdata, 32'd0);
      chk("post_rst_rid", {30'd0, rid}, k);
    end

    // Mixed traffic, checked by the model only.
    for (int t = 0; t < 8; t++) begin
      logic [15:0] v;
      v = mix_tbl[t];
      req = v[15:12];
      we = v[11:8];
      reg_no = v[7:0];
      for (int i = 0; i < 4; i++) wdata[32*i +: 32] = 32'hA5000000 + 32'(t * 16 + i);
      tick();
    end
    clear_all();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
